// File: rtl/ioq_pkg.sv
// Shared types and constants for the IO queue master: FSM states, error bit
// positions and the data path width.
package ioq_pkg;

    localparam int DATA_W       = 32;
    localparam int ERR_W        = 3;
    localparam int ERR_WQ_UNDER = 0;
    localparam int ERR_RQ_OVER  = 1;
    localparam int ERR_TIMEOUT  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } ioq_state_e;

endpackage

// File: rtl/ioq_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags
// and single-cycle drop (push while full) / underflow (pop while empty) strobes.
module ioq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o,
    output logic             under_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    // An empty FIFO with push and pop together hands the word straight through.
    assign do_pop  = pop_i && (!empty_q || push_i);
    assign do_push = push_i && (!full_q || pop_i);
    assign drop_o  = push_i && !do_push;
    assign under_o = pop_i && !do_pop;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = !empty_q ? mem_q[rd_ptr_q] : ((push_i && pop_i) ? data_i : '0);
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/ioq_master.sv
// CPU-side IO queue initiator: owns WQ/RQ/AQ and dispatches AQ commands to devices
// one at a time. Define IOQ_TIMEOUT_EN to add the WAIT-state watchdog (err[2]).
module ioq_master
    import ioq_pkg::*;
#(
    parameter int NDEV     = 4,
    parameter int DEVW     = 2,
    parameter int WQ_DEPTH = 16,
    parameter int RQ_DEPTH = 16,
    parameter int AQ_DEPTH = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] wqData,
    input  logic              wqWr,
    output logic              wqFull,
    input  logic [DEVW-1:0]   aqDev,
    input  logic              aqWr,
    output logic              aqFull,
    output logic [DATA_W-1:0] rqData,
    input  logic              rqRd,
    output logic              rqEmpty,
    output logic [DATA_W-1:0] wq,
    input  logic              rwq,
    input  logic [DATA_W-1:0] rq,
    input  logic              wrq,
    input  logic              done,
    output logic [NDEV-1:0]   sel,
    output logic              busy,
    output logic [ERR_W-1:0]  err
);
    ioq_state_e       state_q, state_d;
    logic [DEVW-1:0]  dev_q, dev_d;
    logic [NDEV-1:0]  sel_q, sel_d;
    logic             busy_q, busy_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic             wq_under, rq_drop, aq_empty, aq_pop, timeout_hit, dev_invalid;
    logic [DEVW-1:0]  aq_head;
    logic             wq_empty_unused, wq_drop_unused, rq_full_unused, rq_under_unused;
    logic             aq_drop_unused, aq_under_unused;

    ioq_fifo #(.WIDTH(DATA_W), .DEPTH(WQ_DEPTH)) u_wq (
        .clock(clock), .reset(reset), .push_i(wqWr), .data_i(wqData), .pop_i(rwq),
        .data_o(wq), .full_o(wqFull), .empty_o(wq_empty_unused),
        .drop_o(wq_drop_unused), .under_o(wq_under)
    );

    ioq_fifo #(.WIDTH(DATA_W), .DEPTH(RQ_DEPTH)) u_rq (
        .clock(clock), .reset(reset), .push_i(wrq), .data_i(rq), .pop_i(rqRd),
        .data_o(rqData), .full_o(rq_full_unused), .empty_o(rqEmpty),
        .drop_o(rq_drop), .under_o(rq_under_unused)
    );

    ioq_fifo #(.WIDTH(DEVW), .DEPTH(AQ_DEPTH)) u_aq (
        .clock(clock), .reset(reset), .push_i(aqWr), .data_i(aqDev), .pop_i(aq_pop),
        .data_o(aq_head), .full_o(aqFull), .empty_o(aq_empty),
        .drop_o(aq_drop_unused), .under_o(aq_under_unused)
    );

    // A command to a nonexistent device drives no select and retires at once.
    assign dev_invalid = (32'(dev_q) >= NDEV);

`ifdef IOQ_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt_q;

    always_ff @(posedge clock) begin
        if (reset || state_q == ISSUE) begin
            tmo_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == WAIT) && (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        dev_d   = dev_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        err_d   = err_q;
        aq_pop  = 1'b0;
        if (wq_under) err_d[ERR_WQ_UNDER] = 1'b1;
        if (rq_drop)  err_d[ERR_RQ_OVER]  = 1'b1;
        case (state_q)
            IDLE: begin
                if (!aq_empty) begin
                    dev_d   = aq_head;
                    aq_pop  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                sel_d   = NDEV'(1) << dev_q;
                state_d = WAIT;
            end
            WAIT: begin
                if (done || dev_invalid || timeout_hit) begin
                    if (timeout_hit && !done) err_d[ERR_TIMEOUT] = 1'b1;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                sel_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            dev_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            dev_q   <= dev_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign sel  = sel_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_ioq_master.sv
// Scoreboard bench for ioq_master with a 32x32 signed multiplier model on dev 1.
// With IOQ_TIMEOUT_EN defined it also exercises the watchdog on a silent dev 2.
module tb_ioq_master;
    localparam int NDEV = 4;
    localparam int DEVW = 2;
    localparam int TMO  = 20;

    logic            clock = 1'b0;
    logic            reset;
    logic [31:0]     wqData;
    logic            wqWr, wqFull;
    logic [DEVW-1:0] aqDev;
    logic            aqWr, aqFull;
    logic [31:0]     rqData;
    logic            rqRd, rqEmpty;
    logic [31:0]     wq;
    logic            rwq;
    logic [31:0]     rq;
    logic            wrq, done;
    logic [NDEV-1:0] sel;
    logic            busy;
    logic [2:0]      err;

    logic            tb_rwq, tb_wrq;
    logic [31:0]     tb_rq;
    logic            m_rwq, m_wrq, m_done;
    logic [31:0]     m_rq;

    assign rwq  = tb_rwq | m_rwq;
    assign wrq  = tb_wrq | m_wrq;
    assign rq   = tb_rq | m_rq;
    assign done = m_done;

    always #5 clock = ~clock;

    ioq_master #(
        .NDEV(NDEV), .DEVW(DEVW), .WQ_DEPTH(16), .RQ_DEPTH(16), .AQ_DEPTH(8), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset(reset), .wqData(wqData), .wqWr(wqWr), .wqFull(wqFull),
        .aqDev(aqDev), .aqWr(aqWr), .aqFull(aqFull), .rqData(rqData), .rqRd(rqRd),
        .rqEmpty(rqEmpty), .wq(wq), .rwq(rwq), .rq(rq), .wrq(wrq), .done(done),
        .sel(sel), .busy(busy), .err(err)
    );

    // Multiplier model: pops A then B, pushes low then high word, pulses done on
    // its 8th selected cycle.
    logic [2:0]  m_k;
    logic [31:0] m_a, m_b;
    logic [63:0] m_p;

    always_ff @(posedge clock) begin
        if (reset || !sel[1]) begin
            m_k <= 3'd0;
        end else begin
            m_k <= m_k + 3'd1;
            if (m_k == 3'd0) m_a <= wq;
            if (m_k == 3'd1) m_b <= wq;
        end
    end

    assign m_p = $signed({{32{m_a[31]}}, m_a}) * $signed({{32{m_b[31]}}, m_b});

    always_comb begin
        m_rwq  = sel[1] && (m_k == 3'd0 || m_k == 3'd1);
        m_wrq  = sel[1] && (m_k == 3'd5 || m_k == 3'd6);
        m_done = sel[1] && (m_k == 3'd7);
        m_rq   = 32'd0;
        if (sel[1] && m_k == 3'd5) m_rq = m_p[31:0];
        if (sel[1] && m_k == 3'd6) m_rq = m_p[63:32];
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb[$];
    int          w_q[$];
    int          g_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_wq(input logic [31:0] d);
        wqData = d; wqWr = 1'b1;
        tick();
        wqWr = 1'b0;
        $display("wq push: %08h", d);
    endtask

    task automatic push_aq(input logic [DEVW-1:0] d);
        aqDev = d; aqWr = 1'b1;
        tick();
        aqWr = 1'b0;
        $display("aq push: dev %0d", d);
    endtask

    task automatic mul_cmd(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        push_wq(a);
        push_wq(b);
        sb.push_back(p[31:0]);
        sb.push_back(p[63:32]);
    endtask

    // Pops RQ until empty, comparing each word with the scoreboard head.
    task automatic drain();
        logic [63:0] exp;
        int guard = 0;
        while (!rqEmpty && guard < 64) begin
            exp = (sb.size() > 0) ? 64'(sb.pop_front()) : 64'hBAD0_0000_0000_0000;
            $display("rq pop: %08h", rqData);
            check_val("rq_data", 64'(rqData), exp);
            rqRd = 1'b1;
            tick();
            rqRd = 1'b0;
            guard++;
        end
        check_val("rq_left", 64'(sb.size()), 64'd0);
    endtask

    // Samples sel[dev] for ncyc cycles, collecting window widths and gaps.
    task automatic record(input int dev, input int ncyc);
        int  run = 0;
        int  low = 0;
        bit  seen = 1'b0;
        w_q.delete();
        g_q.delete();
        for (int i = 0; i < ncyc; i++) begin
            if (sel[dev]) begin
                if (run == 0 && seen) g_q.push_back(low);
                run++;
                low = 0;
            end else begin
                if (run > 0) begin
                    w_q.push_back(run);
                    seen = 1'b1;
                    run  = 0;
                end
                low++;
            end
            tick();
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        reset = 1'b1; wqData = '0; wqWr = 1'b0; aqDev = '0; aqWr = 1'b0; rqRd = 1'b0;
        tb_rwq = 1'b0; tb_wrq = 1'b0; tb_rq = '0;
        tick(); tick();
        reset = 1'b0;
        tick();

        check_val("rst_sel", 64'(sel), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_err", 64'(err), 64'd0);
        check_val("rst_wqfull", 64'(wqFull), 64'd0);
        check_val("rst_aqfull", 64'(aqFull), 64'd0);
        check_val("rst_rqempty", 64'(rqEmpty), 64'd1);
        check_val("rst_wq", 64'(wq), 64'd0);
        check_val("rst_rqdata", 64'(rqData), 64'd0);

        // 3 * 5
        mul_cmd(32'd3, 32'd5);
        push_aq(2'd1);
        record(1, 20);
        check_val("mul_win_cnt", 64'(w_q.size()), 64'd1);
        check_val("mul_win_len", 64'(qget(w_q, 0)), 64'd8);
        check_val("mul_busy", 64'(busy), 64'd0);
        check_val("mul_err", 64'(err), 64'd0);
        drain();

        // Signed: -1 * 2
        mul_cmd(32'hFFFF_FFFF, 32'h0000_0002);
        push_aq(2'd1);
        record(1, 20);
        check_val("smul_win_len", 64'(qget(w_q, 0)), 64'd8);
        drain();

        // Three queued commands
        for (int i = 0; i < 3; i++) mul_cmd($urandom, $urandom);
        fork
            record(1, 60);
            begin
                push_aq(2'd1);
                push_aq(2'd1);
                push_aq(2'd1);
            end
        join
        check_val("b2b_win_cnt", 64'(w_q.size()), 64'd3);
        for (int i = 0; i < 3; i++) check_val("b2b_win_len", 64'(qget(w_q, i)), 64'd8);
        check_val("b2b_gap_cnt", 64'(g_q.size()), 64'd2);
        for (int i = 0; i < 2; i++) check_val("b2b_gap_len", 64'(qget(g_q, i)), 64'd2);
        check_val("b2b_wq_empty", 64'(wq), 64'd0);
        drain();

        // WQ full and drop, then underflow
        for (int i = 0; i < 17; i++) begin
            push_wq(32'h100 + 32'(i));
            if (i >= 15) check_val("wq_full", 64'(wqFull), 64'd1);
        end
        for (int i = 0; i < 16; i++) begin
            check_val("wq_head", 64'(wq), 64'h100 + 64'(i));
            tb_rwq = 1'b1; tick(); tb_rwq = 1'b0;
        end
        check_val("wq_drained", 64'(wq), 64'd0);
        check_val("wq_nofull", 64'(wqFull), 64'd0);
        check_val("err_clean", 64'(err), 64'd0);
        tb_rwq = 1'b1; tick(); tb_rwq = 1'b0;
        $display("rwq on empty WQ");
        check_val("err_under", 64'(err), 64'b001);

        // RQ overflow
        for (int i = 0; i < 17; i++) begin
            tb_rq = 32'h200 + 32'(i); tb_wrq = 1'b1;
            if (i < 16) sb.push_back(32'h200 + 32'(i));
            tick();
            tb_wrq = 1'b0; tb_rq = '0;
            $display("rq device push: %08h", 32'h200 + 32'(i));
        end
        check_val("err_over", 64'(err), 64'b011);
        drain();

        // Reset in WAIT; a leftover WQ word must be flushed too
        mul_cmd(32'd7, 32'd9);
        push_wq(32'hDEAD);
        push_aq(2'd1);
        for (int i = 0; i < 10 && !sel[1]; i++) tick();
        check_val("mid_sel_rise", 64'(sel[1]), 64'd1);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        $display("reset asserted in WAIT");
        check_val("mid_sel", 64'(sel), 64'd0);
        check_val("mid_rqempty", 64'(rqEmpty), 64'd1);
        check_val("mid_err", 64'(err), 64'd0);
        check_val("mid_busy", 64'(busy), 64'd0);
        check_val("mid_wq", 64'(wq), 64'd0);
        reset = 1'b0;
        sb.delete();
        tick();
        mul_cmd(32'd6, 32'd7);
        push_aq(2'd1);
        record(1, 20);
        check_val("post_win_len", 64'(qget(w_q, 0)), 64'd8);
        drain();

`ifdef IOQ_TIMEOUT_EN
        push_aq(2'd2);
        record(2, 40);
        check_val("tmo_win_cnt", 64'(w_q.size()), 64'd1);
        check_val("tmo_win_len", 64'(qget(w_q, 0)), 64'(TMO));
        check_val("tmo_err", 64'(err), 64'b100);
        mul_cmd(32'd4, 32'd5);
        push_aq(2'd1);
        record(1, 20);
        check_val("tmo_next_len", 64'(qget(w_q, 0)), 64'd8);
        drain();
`else
        check_val("no_tmo_err", 64'(err), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
